rom_fetch_ctrl: RTL

//  Initiator side of the ROM read interface: walks a ROM with a combinational

---
 rtl/rom_fetch_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rom_fetch_ctrl.sv
// Streams a programmed address range of a combinational ROM into a small output FIFO.
// Optional ROM_FETCH_WRAP_EN: addresses wrap past the top of the ROM instead of raising an error.
module rom_fetch_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  rom_error_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic                  mem_last_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [PW:0]           count_q;
  logic                  full, pop, fetch_try, fetch_err, push, flush, range_err;

  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop       = m_valid_o && m_ready_i;
  assign fetch_try = (state_q == FETCH) && (!full || pop);
  assign fetch_err = fetch_try && (rom_error_i || range_err);
  assign push      = fetch_try && !fetch_err;
  assign flush     = abort_i || fetch_err;

`ifdef ROM_FETCH_WRAP_EN
  assign range_err = 1'b0;
`else
  logic oob_q;

  // Armed after fetching the top word with more to go; the next fetch attempt faults.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      oob_q <= 1'b0;
    end else if (flush || state_q != FETCH) begin
      oob_q <= 1'b0;
    end else if (push && addr_q == '1 && remain_q > (ADDR_WIDTH+1)'(1)) begin
      oob_q <= 1'b1;
    end
  end

  assign range_err = oob_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    err_d    = err_q;
    done_d   = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_d   = base_addr_i;
            remain_d = len_i;
            err_d    = 1'b0;
            if (len_i == '0) done_d = 1'b1;
            else             state_d = FETCH;
          end
        end
        FETCH: begin
          if (fetch_err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (push) begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            remain_d = remain_q - (ADDR_WIDTH+1)'(1);
            if (remain_q == (ADDR_WIDTH+1)'(1)) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last_o) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o     = (state_q == FETCH) || (state_q == DRAIN);
    done_o     = done_q;
    err_o      = err_q;
    rom_addr_o = addr_q;
    m_valid_o  = (count_q != '0);
    m_data_o   = mem_data_q[rptr_q];
    m_last_o   = mem_last_q[rptr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_data_q[wptr_q] <= rom_data_i;
        mem_last_q[wptr_q] <= (remain_q == (ADDR_WIDTH+1)'(1));
        wptr_q             <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
